// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer controller for the shared tri-state datapath bus.
// Define XFER_TURNAROUND_EN to insert one bus-idle TURN cycle between back-to-back transfers.
module bus_xfer_ctrl #(
  parameter int N_SRC = 8,
  parameter int N_DST = 8,
  parameter int W     = 16,
  parameter int SRC_W = $clog2(N_SRC),
  parameter int DST_W = $clog2(N_DST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [SRC_W-1:0] req_src,
  input  logic [DST_W-1:0] req_dst,
  output logic             req_ready,
  input  logic [W-1:0]     bus_in,
  output logic [N_SRC-1:0] src_en,
  output logic [N_DST-1:0] dst_load,
  output logic [W-1:0]     dst_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRIVE   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;
`ifdef XFER_TURNAROUND_EN
  localparam logic [2:0] TURN    = 3'd4;
`endif

  logic [2:0]       state_reg, state_next;
  logic [SRC_W-1:0] q_src [2];
  logic [DST_W-1:0] q_dst [2];
  logic             rd_ptr_reg, wr_ptr_reg;
  logic [1:0]       count_reg;
  logic [SRC_W-1:0] cur_src_reg;
  logic [DST_W-1:0] cur_dst_reg;
  logic [W-1:0]     data_reg;
  logic             err_reg;

  logic             push, pop, head_ok;
  logic [SRC_W-1:0] head_src;
  logic [DST_W-1:0] head_dst;

  assign req_ready = (count_reg != 2'd2);
  assign push      = req_valid && req_ready;
  assign head_src  = q_src[rd_ptr_reg];
  assign head_dst  = q_dst[rd_ptr_reg];
  // Range check happens at pop so a bad request still consumes its queue slot.
  assign head_ok   = (int'(head_src) < N_SRC) && (int'(head_dst) < N_DST);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) begin
          pop        = 1'b1;
          state_next = head_ok ? DRIVE : IDLE;
        end
      end
      DRIVE:   state_next = CAPTURE;
      CAPTURE: state_next = LOAD;
      LOAD: begin
`ifdef XFER_TURNAROUND_EN
        state_next = (count_reg != 2'd0) ? TURN : IDLE;
`else
        if (count_reg != 2'd0) begin
          pop        = 1'b1;
          state_next = head_ok ? DRIVE : IDLE;
        end else begin
          state_next = IDLE;
        end
`endif
      end
`ifdef XFER_TURNAROUND_EN
      TURN: begin
        if (count_reg != 2'd0) begin
          pop        = 1'b1;
          state_next = head_ok ? DRIVE : IDLE;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr_reg] <= req_src;
      q_dst[wr_ptr_reg] <= req_dst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_ptr_reg  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
      cur_src_reg <= '0;
      cur_dst_reg <= '0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop) begin
        rd_ptr_reg  <= ~rd_ptr_reg;
        cur_src_reg <= head_src;
        cur_dst_reg <= head_dst;
        if (!head_ok) err_reg <= 1'b1;
      end
      if (state_reg == CAPTURE) data_reg <= bus_in;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_en[gi] = ((state_reg == DRIVE) || (state_reg == CAPTURE)) &&
                          (int'(cur_src_reg) == gi);
    end
    for (genvar gi = 0; gi < N_DST; gi++) begin : g_dst
      assign dst_load[gi] = (state_reg == LOAD) && (int'(cur_dst_reg) == gi);
    end
  endgenerate

  assign dst_data = data_reg;
  assign done     = (state_reg == LOAD);
  assign busy     = (state_reg != IDLE) || (count_reg != 2'd0);
  assign err      = err_reg;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed vector table, multi-cycle sequences, random stream with scoreboard.
module tb_bus_xfer_ctrl;
  localparam int N_SRC = 8;
  localparam int N_DST = 8;
  localparam int W     = 16;
  localparam int SW    = 4;
  localparam int DW    = 4;
`ifdef XFER_TURNAROUND_EN
  localparam int PER = 4;
`else
  localparam int PER = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_src = '0;
  logic [DW-1:0] req_dst = '0;
  logic          req_ready;
  logic [W-1:0]  bus_in;
  logic [N_SRC-1:0] src_en;
  logic [N_DST-1:0] dst_load;
  logic [W-1:0]  dst_data;
  logic          busy, done, err;

  logic [W-1:0]  src_val [N_SRC];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int n_loads = 0;

  typedef struct {
    int           dst;
    logic [W-1:0] data;
  } exp_t;
  exp_t model_q[$];
  int   load_cyc[$];

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] dst;
    logic [W-1:0]  bus;
    logic [7:0]    exp_src_en;
    logic [7:0]    exp_dst_load;
    logic [W-1:0]  exp_data;
    logic          exp_done;
    logic          exp_err;
  } vec_t;
  vec_t vecs[7];

  bus_xfer_ctrl #(.N_SRC(N_SRC), .N_DST(N_DST), .W(W), .SRC_W(SW), .DST_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
    .req_ready(req_ready), .bus_in(bus_in), .src_en(src_en), .dst_load(dst_load),
    .dst_data(dst_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: every enabled source contributes its word (multi-hot would corrupt it).
  always_comb begin
    bus_in = '0;
    for (int i = 0; i < N_SRC; i++) if (src_en[i]) bus_in = bus_in | src_val[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: accepted in-range requests must each load once, in order, with the source's word.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (req_valid && req_ready && int'(req_src) < N_SRC && int'(req_dst) < N_DST)
        model_q.push_back('{int'(req_dst), src_val[req_src[2:0]]});
      check("src_en_onehot0", 32'($countones(src_en) <= 1), 32'd1);
      check("src_load_exclusive", 32'((src_en != 0) && (dst_load != 0)), 32'd0);
      check("done_matches_load", 32'(done), 32'(dst_load != 0));
      if (dst_load != 0) begin
        n_loads++;
        load_cyc.push_back(cyc);
        check("load_expected", 32'(model_q.size() != 0), 32'd1);
        if (model_q.size() != 0) begin
          e = model_q.pop_front();
          check("load_dst", 32'(dst_load), 32'(1) << e.dst);
          check("load_data", 32'(dst_data), 32'(e.data));
        end
      end
    end
  end

  task automatic send(input int s, input int d, output int acc);
    req_valid = 1'b1;
    req_src   = SW'(s);
    req_dst   = DW'(d);
    acc       = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc + 1;
        @(posedge clk);
        #1;
        break;
      end
    end
    req_valid = 1'b0;
    check("accepted", 32'(acc >= 0), 32'd1);
  endtask

  task automatic at_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int t, t2, sent, guard;
    bit fire, seen;

    for (int i = 0; i < N_SRC; i++) src_val[i] = '0;
    vecs[0] = '{4'd3, 4'd5,  16'hA5C3, 8'h08, 8'h20, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{4'd6, 4'd6,  16'h5A5A, 8'h40, 8'h40, 16'h5A5A, 1'b1, 1'b0};
    vecs[2] = '{4'd0, 4'd7,  16'h0001, 8'h01, 8'h80, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{4'd9, 4'd2,  16'h1234, 8'h00, 8'h00, 16'h0001, 1'b0, 1'b1};
    vecs[4] = '{4'd2, 4'd1,  16'hBEEF, 8'h04, 8'h02, 16'hBEEF, 1'b1, 1'b1};
    vecs[5] = '{4'd1, 4'd12, 16'h7777, 8'h00, 8'h00, 16'hBEEF, 1'b0, 1'b1};
    vecs[6] = '{4'd7, 4'd0,  16'hFFFF, 8'h80, 8'h01, 16'hFFFF, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_en", 32'(src_en), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dst_load", 32'(dst_load), 32'd0);
    check("rst_dst_data", 32'(dst_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready_post", 32'(req_ready), 32'd1);

    // Directed single transfers from the vector table
    for (int k = 0; k < 7; k++) begin
      if (int'(vecs[k].src) < N_SRC) src_val[vecs[k].src[2:0]] = vecs[k].bus;
      @(posedge clk);
      #1;
      send(int'(vecs[k].src), int'(vecs[k].dst), t);
      at_cyc(t + 1);
      check($sformatf("v%0d_src_en_t1", k), 32'(src_en), 32'(vecs[k].exp_src_en));
      check($sformatf("v%0d_load_t1", k), 32'(dst_load), 32'd0);
      at_cyc(t + 2);
      check($sformatf("v%0d_src_en_t2", k), 32'(src_en), 32'(vecs[k].exp_src_en));
      at_cyc(t + 3);
      check($sformatf("v%0d_src_en_t3", k), 32'(src_en), 32'd0);
      check($sformatf("v%0d_dst_load", k), 32'(dst_load), 32'(vecs[k].exp_dst_load));
      check($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
      check($sformatf("v%0d_dst_data", k), 32'(dst_data), 32'(vecs[k].exp_data));
      at_cyc(t + 4);
      check($sformatf("v%0d_busy_t4", k), 32'(busy), 32'd0);
      check($sformatf("v%0d_done_t4", k), 32'(done), 32'd0);
      check($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
    end

    // Three back-to-back requests: loads PER cycles apart, in order
    src_val[1] = 16'h1111;
    src_val[4] = 16'h2222;
    src_val[7] = 16'hFFFF;
    model_q.delete();
    load_cyc.delete();
    n_loads = 0;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;
    send(1, 2, t);
    send(4, 0, t2);
    send(7, 7, t2);
    guard = 0;
    while (n_loads < 3 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("seq_load_count", 32'(n_loads), 32'd3);
    if (n_loads >= 3)
      for (int k = 0; k < 3; k++)
        check($sformatf("seq_load%0d_latency", k), 32'(load_cyc[k] - t), 32'(PER * k + 3));
    at_cyc(cyc + 1);
    check("seq_busy_after", 32'(busy), 32'd0);
    mon_en = 1'b0;

    // Asynchronous reset in CAPTURE with a second request queued
    src_val[2] = 16'hCAFE;
    @(posedge clk);
    #1;
    send(2, 6, t);
    send(4, 1, t2);
    at_cyc(t + 2);
    check("pre_reset_src_en", 32'(src_en), 32'h04);
    #1;
    reset = 1'b1;
    #1;
    check("arst_src_en", 32'(src_en), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err_cleared", 32'(err), 32'd0);
    check("arst_dst_load", 32'(dst_load), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dst_load != 0 || src_en != 0 || done) seen = 1'b1;
    end
    check("arst_no_activity", 32'(seen), 32'd0);
    check("arst_busy_after", 32'(busy), 32'd0);

    // Random stream of 200 valid requests against the scoreboard
    for (int i = 0; i < N_SRC; i++) src_val[i] = W'($urandom);
    model_q.delete();
    load_cyc.delete();
    n_loads = 0;
    mon_en  = 1'b1;
    sent    = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5000 && sent < 200; c++) begin
      @(negedge clk);
      fire = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (fire) sent++;
      if (!req_valid || fire) begin
        if (sent < 200 && $urandom_range(0, 2) != 0) begin
          req_valid = 1'b1;
          req_src   = SW'($urandom_range(0, N_SRC - 1));
          req_dst   = DW'($urandom_range(0, N_DST - 1));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    guard = 0;
    while ((busy || model_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rand_sent", 32'(sent), 32'd200);
    check("rand_loads", 32'(n_loads), 32'd200);
    check("rand_queue_drained", 32'(model_q.size()), 32'd0);
    check("rand_err_clear", 32'(err), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
